// File: rtl/sram_bank_arbiter.sv
// Per-bank round-robin arbiter in front of the unified SRAM shared by the SoC and the accelerator.
// Grants are combinational. Read data and errors return to the issuing requester one cycle after the grant.
module sram_bank_arbiter #(
  parameter int WIDTH   = 64,
  parameter int N_REQ   = 2,
  parameter int N_BANK  = 4,
  parameter int BANK_AW = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*32-1:0]       req_addr,
  input  logic [N_REQ*WIDTH-1:0]    req_wdata,
  output logic [N_REQ-1:0]          req_gnt,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [N_REQ*WIDTH-1:0]    rsp_rdata,
  output logic [N_REQ-1:0]          rsp_err,
  output logic [N_BANK-1:0]         bank_we,
  output logic [N_BANK*32-1:0]      bank_addr,
  output logic [N_BANK*WIDTH-1:0]   bank_wdata,
  input  logic [N_BANK*WIDTH-1:0]   bank_rdata
);

  localparam int BW = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(N_BANK) << BANK_AW;

  logic [N_REQ-1:0]  in_range;
  logic [BW-1:0]     req_bank [N_REQ];
  logic [IW-1:0]     rr_ptr   [N_BANK];
  logic [N_BANK-1:0] win_v;
  logic [IW-1:0]     win_id   [N_BANK];
  logic [N_BANK-1:0] tag_v;
  logic [IW-1:0]     tag_id   [N_BANK];
  logic [N_REQ-1:0]  err_gnt;
  logic [N_REQ-1:0]  read_gnt;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [N_REQ-1:0]  rsp_err_q;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      in_range[i] = {1'b0, req_addr[32*i +: 32]} < ADDR_LIMIT;
      req_bank[i] = req_addr[32*i + BANK_AW +: BW];
    end
  end

  // Search each bank starting at its pointer, wrapping modulo N_REQ; first candidate wins.
  always_comb begin
    int idx;
    win_v = '0;
    for (int b = 0; b < N_BANK; b++) begin
      win_id[b] = '0;
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_ptr[b]) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!win_v[b] && !rst && req_valid[idx] && in_range[idx] && req_bank[idx] == BW'(b)) begin
          win_v[b]  = 1'b1;
          win_id[b] = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    err_gnt  = req_valid & ~in_range & {N_REQ{~rst}};
    req_gnt  = err_gnt;
    read_gnt = '0;
    for (int b = 0; b < N_BANK; b++) begin
      if (win_v[b]) begin
        req_gnt[win_id[b]] = 1'b1;
        if (!req_we[win_id[b]]) read_gnt[win_id[b]] = 1'b1;
      end
    end
  end

  // Idle banks see all-zero control so nothing stale reaches the macros.
  always_comb begin
    int wid;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    for (int b = 0; b < N_BANK; b++) begin
      wid = int'(win_id[b]);
      if (win_v[b]) begin
        bank_we[b]                   = req_we[wid];
        bank_addr[32*b +: 32]        = req_addr[32*wid +: 32];
        bank_wdata[WIDTH*b +: WIDTH] = req_wdata[WIDTH*wid +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < N_BANK; b++) begin
        rr_ptr[b] <= '0;
        tag_id[b] <= '0;
      end
      tag_v       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
    end else begin
      for (int b = 0; b < N_BANK; b++) begin
        if (win_v[b]) begin
          rr_ptr[b] <= IW'((int'(win_id[b]) + 1) % N_REQ);
        end
        tag_v[b]  <= win_v[b] & ~req_we[win_id[b]];
        tag_id[b] <= win_id[b];
      end
      rsp_valid_q <= err_gnt | read_gnt;
      rsp_err_q   <= err_gnt;
    end
  end

  // A reset arriving the cycle after a read grant suppresses that response.
  always_comb begin
    rsp_valid = rsp_valid_q & {N_REQ{~rst}};
    rsp_err   = rsp_err_q & {N_REQ{~rst}};
    rsp_rdata = '0;
    if (!rst) begin
      for (int b = 0; b < N_BANK; b++) begin
        if (tag_v[b]) rsp_rdata[WIDTH*int'(tag_id[b]) +: WIDTH] = bank_rdata[WIDTH*b +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Scoreboard bench for sram_bank_arbiter: a reference model predicts grants and responses,
// and a separate monitor checks every response cycle against the expected queue.
module tb_sram_bank_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_we;
  logic [63:0]   req_addr;
  logic [127:0]  req_wdata;
  logic [1:0]    req_gnt, rsp_valid, rsp_err;
  logic [127:0]  rsp_rdata;
  logic [3:0]    bank_we;
  logic [127:0]  bank_addr;
  logic [255:0]  bank_wdata;
  logic [255:0]  bank_rdata;

  sram_bank_arbiter #(.WIDTH(64), .N_REQ(2), .N_BANK(4), .BANK_AW(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] init_val(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  // Synchronous-read SRAM banks, read-before-write.
  logic [63:0] bmem [logic [31:0]];
  always @(posedge clk) begin
    logic [31:0] a;
    logic [63:0] rd;
    for (int b = 0; b < 4; b++) begin
      a  = bank_addr[32*b +: 32];
      rd = bmem.exists(a) ? bmem[a] : init_val(a);
      bank_rdata[64*b +: 64] <= rd;
      if (bank_we[b]) bmem[a] = bank_wdata[64*b +: 64];
    end
  end

  typedef struct {
    int          due;
    logic        err;
    logic [63:0] data;
  } exp_t;
  typedef exp_t exp_q_t[$];

  exp_q_t q0, q1;
  logic [63:0] ref_mem [logic [31:0]];
  int ptr [4];

  logic [1:0]  pv, pwe;
  logic [31:0] pa [2];
  logic [63:0] pd [2];
  logic        rst_cmd;

  function automatic void push_exp(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  // Reference: out-of-range always granted; per bank the valid in-range requester closest
  // at or after the pointer (cyclically) wins, and the pointer moves just past it.
  task automatic model_eval();
    logic [1:0]  eg;
    logic [3:0]  ew;
    logic [31:0] a;
    int          best, bd, d;
    exp_t        e;
    if (rst) begin
      chk("gnt_in_reset", 64'(req_gnt), 64'd0);
      chk("bank_we_in_reset", 64'(bank_we), 64'd0);
      for (int b = 0; b < 4; b++) ptr[b] = 0;
      return;
    end
    eg = '0;
    ew = '0;
    for (int i = 0; i < 2; i++) begin
      a = req_addr[32*i +: 32];
      if (req_valid[i] && a >= 32'h4000) begin
        eg[i] = 1'b1;
        e.due = cyc + 1; e.err = 1'b1; e.data = '0;
        push_exp(i, e);
      end
    end
    for (int b = 0; b < 4; b++) begin
      best = -1;
      bd   = 2;
      for (int i = 0; i < 2; i++) begin
        a = req_addr[32*i +: 32];
        if (req_valid[i] && a < 32'h4000 && int'(a[13:12]) == b) begin
          d = (i - ptr[b] + 2) % 2;
          if (d < bd) begin best = i; bd = d; end
        end
      end
      if (best >= 0) begin
        a = req_addr[32*best +: 32];
        eg[best] = 1'b1;
        ptr[b] = (best + 1) % 2;
        chk("bank_addr", 64'(bank_addr[32*b +: 32]), 64'(a));
        if (req_we[best]) begin
          ew[b] = 1'b1;
          ref_mem[a] = req_wdata[64*best +: 64];
          chk("bank_wdata", bank_wdata[64*b +: 64], req_wdata[64*best +: 64]);
        end else begin
          e.due = cyc + 1; e.err = 1'b0;
          e.data = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
          push_exp(best, e);
        end
      end else begin
        chk("bank_addr_idle", 64'(bank_addr[32*b +: 32]), 64'd0);
      end
    end
    chk("req_gnt", 64'(req_gnt), 64'(eg));
    chk("bank_we", 64'(bank_we), 64'(ew));
    for (int i = 0; i < 2; i++) if (eg[i]) pv[i] = 1'b0;
  endtask

  task automatic mon_one(input int i, inout exp_q_t q);
    exp_t e;
    if (rst) begin
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      chk("rsp_valid_in_reset", 64'(rsp_valid[i]), 64'd0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp_valid", 64'(rsp_valid[i]), 64'd1);
      chk("rsp_err", 64'(rsp_err[i]), 64'(e.err));
      chk("rsp_rdata", rsp_rdata[64*i +: 64], e.data);
    end else begin
      chk("rsp_valid_idle", 64'(rsp_valid[i]), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, q0);
    mon_one(1, q1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    rst       = rst_cmd;
    req_valid = pv;
    req_we    = pwe;
    req_addr  = {pa[1], pa[0]};
    req_wdata = {pd[1], pd[0]};
    @(negedge clk);
    model_eval();
  endtask

  task automatic issue(input int i, input logic we, input logic [31:0] a, input logic [63:0] d);
    pv[i] = 1'b1; pwe[i] = we; pa[i] = a; pd[i] = d;
  endtask

  task automatic wait_gnt(input int i);
    for (int n = 0; n < 8 && pv[i]; n++) step();
    chk("grant_timeout", 64'(pv[i]), 64'd0);
  endtask

  initial begin
    rst = 1'b1; rst_cmd = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    pv = '0; pwe = '0;
    for (int i = 0; i < 2; i++) begin pa[i] = '0; pd[i] = '0; end

    // Reset with both requesters asserting, then first bank-0 conflict.
    issue(0, 1'b0, 32'h0000, 64'd0);
    issue(1, 1'b0, 32'h0008, 64'd0);
    step(); step();
    rst_cmd = 1'b0;
    step();
    chk("first_conflict_winner", 64'(pv), 64'b10);
    wait_gnt(1);
    step();

    // Parallel banks.
    issue(0, 1'b0, 32'h0010, 64'd0);
    issue(1, 1'b0, 32'h2010, 64'd0);
    step();
    chk("parallel_both_granted", 64'(pv), 64'd0);
    step();

    // Continuous conflict on bank 1.
    for (int n = 0; n < 4; n++) begin
      if (!pv[0]) issue(0, 1'b0, 32'h1000 + 32'(n * 8), 64'd0);
      if (!pv[1]) issue(1, 1'b0, 32'h1100 + 32'(n * 8), 64'd0);
      step();
    end
    wait_gnt(0); wait_gnt(1);
    step();

    // Write then read back.
    issue(0, 1'b1, 32'h3004, 64'hDEADBEEF_00000001);
    wait_gnt(0);
    issue(0, 1'b0, 32'h3004, 64'd0);
    wait_gnt(0);
    step();

    // Out-of-range read alongside an in-range write.
    issue(1, 1'b0, 32'h4000, 64'd0);
    issue(0, 1'b1, 32'h0000, 64'h0123_4567_89AB_CDEF);
    step();
    chk("oor_both_granted", 64'(pv), 64'd0);
    step();

    // Reset in the cycle after a read grant.
    issue(0, 1'b0, 32'h1000, 64'd0);
    step();
    rst_cmd = 1'b1;
    step(); step();
    rst_cmd = 1'b0;
    step(); step();

    // Randomized traffic with drops and out-of-range accesses.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (pv[i] && ($urandom % 16) == 0) begin
          pv[i] = 1'b0;
        end else if (!pv[i] && ($urandom % 4) != 0) begin
          if (($urandom % 8) == 0)
            issue(i, 1'($urandom % 2), 32'h4000 + ($urandom % 32'h1000) * 8, {$urandom, $urandom});
          else
            issue(i, 1'($urandom % 2), (($urandom % 4) << 12) | (($urandom % 8) << 3), {$urandom, $urandom});
        end
      end
      step();
    end

    pv = '0;
    step(); step(); step();
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_bank_arbiter.md
# sram_bank_arbiter

Multi-requester arbiter for the four-bank unified SRAM behind the MHSA accelerator. It replaces the static start-based mux between the SoC and the accelerator. Each bank gets its own round-robin arbiter, so requesters hitting different banks are served in the same cycle. The block returns one-cycle-latency read data to the requester that issued each read and flags out-of-range accesses.

## Interface
Parameters:
- WIDTH, 64, data width of requester and bank ports
- N_REQ, 2, number of requesters (index 0 = SoC, 1 = accelerator)
- N_BANK, 4, number of banks; must be a power of two
- BANK_AW, 12, address bits per bank; bank = addr[BANK_AW +: log2(N_BANK)]

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  request valid, one bit per requester
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*32  request address; requester i uses bits [32*i +: 32]
- req_wdata  in  N_REQ*WIDTH  write data
- req_gnt  out  N_REQ  grant; the transfer happens in a cycle where req_valid & req_gnt
- rsp_valid  out  N_REQ  read-data or error response valid
- rsp_rdata  out  N_REQ*WIDTH  read data; 0 on error
- rsp_err  out  N_REQ  qualifies rsp_valid; 1 = out-of-range access
- bank_we  out  N_BANK  bank write enable
- bank_addr  out  N_BANK*32  bank address; full requester address is passed through
- bank_wdata  out  N_BANK*WIDTH  bank write data
- bank_rdata  in  N_BANK*WIDTH  bank read data; valid one cycle after the address is presented

## Operation
- Decode: per requester, in_range = (req_addr < N_BANK << BANK_AW). The bank index comes from the address bits given for BANK_AW.
- Per-bank arbitration (combinational):
  - Candidates are requesters with req_valid & in_range & bank == b.
  - Search starts at rr_ptr[b] and wraps modulo N_REQ; the first candidate found wins.
- Pointer update: on a grant to requester i at bank b, rr_ptr[b] <= (i+1) mod N_REQ. With no grant, the pointer holds.
- Granted bank signals: bank_addr/bank_wdata take the winner's values; bank_we = winner's req_we.
- Ungranted bank signals: bank_we = 0, bank_addr = 0, bank_wdata = 0.
- Out-of-range request: granted in the same cycle unconditionally. No bank is accessed. The next cycle gives rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, for both reads and writes.
- Reads: a per-bank registered tag {valid, requester id} records the grant. The next cycle routes bank_rdata[b] to rsp_rdata of the tagged requester, with rsp_valid = 1 and rsp_err = 0.
- Writes: the transfer completes at grant. No rsp_valid is generated.
- Requesters must hold valid/we/addr/wdata stable until granted. The arbiter does not check this.
- A requester has at most one request per cycle, so at most one response per requester per cycle. Responses arrive in issue order.

## Timing
- Reset values:
  - Registered: rr_ptr = 0 for every bank, all read tags invalid, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - Combinational: while rst = 1, req_gnt = 0 and bank_we = 0.
- Grant latency is 0 cycles: req_gnt is combinational in the cycle of req_valid if the requester wins.
- Read latency: response exactly 1 cycle after the grant cycle. Back-to-back granted reads give a response every cycle.
- Error latency: 1 cycle after the grant.
- Response outputs are registered. rsp_valid is a single-cycle pulse per accepted read or error.
- Contention: the loser waits. Worst-case wait is N_REQ-1 cycles while other requesters keep requesting the same bank.
- Reset in the cycle after a read grant: the tag is cleared and no rsp_valid is produced.
- Deasserting req_valid before a grant is legal; the request is dropped with no state change.

## Test plan
- Reset:
  - Stimulus: hold rst for 2 cycles with req_valid = 2'b11.
  - Required: req_gnt = 0, bank_we = 0, rsp_valid = 0. After release, rr_ptr = 0 and requester 0 wins the first bank-0 conflict.
- Parallel banks:
  - Stimulus: req0 reads 0x0010 (bank 0), req1 reads 0x2010 (bank 2) in the same cycle.
  - Required: both granted in that cycle. The next cycle gives both rsp_valid with the corresponding bank_rdata.
- Conflict round-robin:
  - Stimulus: both requesters read bank 1 continuously for 4 cycles.
  - Required: grants alternate 0,1,0,1. Each response arrives 1 cycle after its own grant.
- Write then read:
  - Stimulus: req0 writes 0xDEADBEEF_00000001 to 0x3004, then reads 0x3004.
  - Required: bank_we[3] = 1 in the write cycle, no rsp for the write. The read returns 0xDEADBEEF_00000001 one cycle after its grant.
- Out-of-range:
  - Stimulus: req1 reads 0x4000 while req0 writes 0x0000.
  - Required: both granted. The next cycle gives rsp_valid[1] = 1, rsp_err[1] = 1, rdata = 0. Only bank_we[0] was asserted.
- Mid-flight reset:
  - Stimulus: grant a read at 0x1000, assert rst the next cycle.
  - Required: rsp_valid stays 0 through and after the reset.
